// File: rtl/tournament_pipe_if.sv
// Request/result bundle for tournament_pipe.
// The slave side is the selector; the master side is whoever issues
// requests and consumes results.
interface tournament_pipe_if #(
    parameter int NUM_ENTRY = 20,
    parameter int WIDTH_KEY = 8,
    parameter int WIDTH_IDX = $clog2(NUM_ENTRY)
);
    logic                 I_Valid;
    logic                 O_Ready;
    logic                 I_Mode;
    logic [NUM_ENTRY-1:0] I_Mask;
    logic [WIDTH_KEY-1:0] I_Key [NUM_ENTRY];
    logic                 O_Valid;
    logic                 I_Ready;
    logic [WIDTH_KEY-1:0] O_Key;
    logic [WIDTH_IDX-1:0] O_Index;
    logic [NUM_ENTRY-1:0] O_Grant;
    logic                 O_Empty;

    modport master (
        output I_Valid, I_Mode, I_Mask, I_Key, I_Ready,
        input  O_Ready, O_Valid, O_Key, O_Index, O_Grant, O_Empty
    );

    modport slave (
        input  I_Valid, I_Mode, I_Mask, I_Key, I_Ready,
        output O_Ready, O_Valid, O_Key, O_Index, O_Grant, O_Empty
    );
endinterface

// File: rtl/tournament_pipe.sv
// Pipelined radix-4 tournament selector: picks the largest (mode 1) or
// smallest (mode 0) key among masked-in entries, lowest index on ties.
// The tree is stored heap-style: node 0 is the root, children of node n
// are 4n+1..4n+4; indices past the internal nodes address the leaves.
// Every internal node is a register, so tree depth d sits in pipeline
// stage NUM_LEVEL-1-d and the result emerges after NUM_LEVEL cycles.
module tournament_pipe #(
    parameter int NUM_ENTRY = 20,
    parameter int WIDTH_KEY = 8,
    parameter int WIDTH_IDX = $clog2(NUM_ENTRY),
    parameter int NUM_LEVEL = ($clog2(NUM_ENTRY) + 1) / 2
) (
    input  logic            clock,
    input  logic            reset,
    tournament_pipe_if.slave bus
);

    localparam int N_LEAF = 4 ** NUM_LEVEL;
    localparam int N_INT  = (N_LEAF - 1) / 3;
    localparam int MODE_W = (NUM_LEVEL > 1) ? NUM_LEVEL - 1 : 1;

    typedef struct packed {
        logic                 part;
        logic [WIDTH_IDX-1:0] idx;
        logic [WIDTH_KEY-1:0] key;
    } cand_t;

    function automatic int node_depth(input int n);
        int d;
        int m;
        d = 0;
        m = n;
        while (m > 0) begin
            m = (m - 1) / 4;
            d = d + 1;
        end
        return d;
    endfunction

    // Strict compare: an equal key never displaces the earlier (lower-index)
    // candidate, which gives the lower-index tie-break at every level.
    function automatic logic beats(input cand_t c, input cand_t b, input logic mode);
        if (!c.part) return 1'b0;
        if (!b.part) return 1'b1;
        return mode ? (c.key > b.key) : (c.key < b.key);
    endfunction

    function automatic cand_t pick4(input cand_t c0, input cand_t c1,
                                    input cand_t c2, input cand_t c3,
                                    input logic mode);
        cand_t best;
        best = c0;
        if (beats(c1, best, mode)) best = c1;
        if (beats(c2, best, mode)) best = c2;
        if (beats(c3, best, mode)) best = c3;
        if (!best.part) best = '0;
        return best;
    endfunction

    logic [NUM_LEVEL-1:0] r_valid;
    logic [MODE_W-1:0]    r_mode;
    cand_t                r_node [N_INT];
    cand_t                w_next [N_INT];
    cand_t                w_leaf [N_LEAF];
    logic                 w_advance;
    logic [NUM_ENTRY-1:0] w_grant;

    assign w_advance = ~r_valid[NUM_LEVEL-1] | bus.I_Ready;

    // Leaves are gated by I_Valid so that idle cycles load all-zero stage data.
    for (genvar j = 0; j < N_LEAF; j++) begin : g_leaf
        if (j < NUM_ENTRY) begin : g_real
            assign w_leaf[j] = (bus.I_Valid & bus.I_Mask[j])
                             ? cand_t'{1'b1, WIDTH_IDX'(j), bus.I_Key[j]}
                             : '0;
        end else begin : g_pad
            assign w_leaf[j] = '0;
        end
    end

    for (genvar n = 0; n < N_INT; n++) begin : g_node
        localparam int STAGE = NUM_LEVEL - 1 - node_depth(n);
        cand_t w_c [4];
        logic  w_mode;

        for (genvar k = 0; k < 4; k++) begin : g_child
            localparam int C = 4 * n + 1 + k;
            if (C >= N_INT) begin : g_from_leaf
                assign w_c[k] = w_leaf[C - N_INT];
            end else begin : g_from_node
                assign w_c[k] = r_node[C];
            end
        end

        if (STAGE == 0) begin : g_mode_in
            assign w_mode = bus.I_Mode;
        end else begin : g_mode_reg
            assign w_mode = r_mode[STAGE-1];
        end

        assign w_next[n] = pick4(w_c[0], w_c[1], w_c[2], w_c[3], w_mode);
    end

    // Pipeline advance: every stage shifts together or holds together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            r_mode  <= '0;
            for (int n = 0; n < N_INT; n++) r_node[n] <= '0;
        end else if (w_advance) begin
            r_valid <= (r_valid << 1) | NUM_LEVEL'(bus.I_Valid);
            r_mode  <= (r_mode << 1) | MODE_W'(bus.I_Valid & bus.I_Mode);
            for (int n = 0; n < N_INT; n++) r_node[n] <= w_next[n];
        end
    end

    // One-hot grant of the root survivor, zero when nobody participated.
    always_comb begin
        w_grant = '0;
        for (int j = 0; j < NUM_ENTRY; j++) begin
            if (r_node[0].part && (r_node[0].idx == WIDTH_IDX'(j))) w_grant[j] = 1'b1;
        end
    end

    assign bus.O_Ready = w_advance;
    assign bus.O_Valid = r_valid[NUM_LEVEL-1];
    assign bus.O_Key   = r_node[0].key;
    assign bus.O_Index = r_node[0].idx;
    assign bus.O_Grant = w_grant;
    // Qualified by valid so that bubbles and the reset state read as not-empty.
    assign bus.O_Empty = r_valid[NUM_LEVEL-1] & ~r_node[0].part;

endmodule
